pid_loop_sequencer: RTL and testbench

PID_LOOP_SEQUENCER -- requirements
Module: pid_loop_sequencer

---
 rtl/pid_pkg.sv | 26 ++
 rtl/pid_gain_lut.sv | 27 ++
 rtl/pid_loop_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pid_loop_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// pid_pkg
// Shared definitions for the PID loop sequencer and the PID core:
//   - seq_state_t : sequencer state encoding
//   - gain_sel_t  : gain-select field of a configuration write (cfg_data[5:4])
//   - TIMEOUT_DEFAULT, GAIN_W, CODE_W : common sizes and defaults
package pid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    SEL_KP   = 2'b00,
    SEL_KI   = 2'b01,
    SEL_KD   = 2'b10,
    SEL_NONE = 2'b11
  } gain_sel_t;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int GAIN_W          = 9;
  localparam int CODE_W          = 4;

endpackage

// File: rtl/pid_gain_lut.sv
// pid_gain_lut
// Combinational decode of a 4-bit gain code into a 9-bit gain (gain x50).
// Codes 0..10 are linear (5 per step); 11..15 give a coarse high range.
// Ports:
//   code : 4-bit gain code
//   gain : decoded 9-bit gain
module pid_gain_lut
  import pid_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [GAIN_W-1:0] gain
);

  // Linear region is computed, the coarse high range is tabulated.
  always_comb begin
    gain = '0;
    case (code)
      4'd11:   gain = 9'd100;
      4'd12:   gain = 9'd150;
      4'd13:   gain = 9'd250;
      4'd14:   gain = 9'd350;
      4'd15:   gain = 9'd500;
      default: gain = GAIN_W'(code) * GAIN_W'(5);
    endcase
  end

endmodule

// File: rtl/pid_loop_sequencer.sv
// pid_loop_sequencer
// Loads the three PID gains while idle, then paces the PID core: every
// P_eff+1 cycles (P_eff = max(period, 2)) it issues a one-cycle core_start
// and waits for core_done. Missed sample ticks raise the sticky overrun
// flag; a core that never answers within TIMEOUT cycles raises fault.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   enable            : run request
//   cfg_valid/ready   : gain-write handshake, cfg_data = {2'bx, sel[1:0], code[3:0]}
//   period            : sample interval minus 1
//   core_start/done   : start strobe to / completion pulse from the PID core
//   kp, ki, kd        : decoded gains
//   gains_valid       : all three gains written since reset
//   busy              : sequencer in RUN or WAIT
//   overrun, fault    : sticky missed-tick flag, core timeout flag
//   clear_fault       : clears fault (in FAULT) and overrun (in FAULT or IDLE)
module pid_loop_sequencer
  import pid_pkg::*;
#(
  parameter int TIMEOUT  = TIMEOUT_DEFAULT,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [7:0]          cfg_data,
  input  logic [PERIOD_W-1:0] period,
  output logic                core_start,
  input  logic                core_done,
  output logic [GAIN_W-1:0]   kp,
  output logic [GAIN_W-1:0]   ki,
  output logic [GAIN_W-1:0]   kd,
  output logic                gains_valid,
  output logic                busy,
  output logic                overrun,
  output logic                fault,
  input  logic                clear_fault
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  seq_state_t          state, state_next;
  logic [PERIOD_W-1:0] per_cnt, per_cnt_next, p_eff;
  logic [TO_W-1:0]     to_cnt, to_cnt_next;
  logic [2:0]          mask, mask_next;
  logic [GAIN_W-1:0]   kp_next, ki_next, kd_next, lut_gain;
  logic                start_next, overrun_next;
  logic                cfg_fire, tick, timeout_hit;
  logic                unused_cfg_bits;

  assign unused_cfg_bits = ^cfg_data[7:6];

  pid_gain_lut u_gain_lut (
    .code (cfg_data[3:0]),
    .gain (lut_gain)
  );

  assign cfg_fire    = cfg_valid && cfg_ready;
  // Periods below 2 are clamped so a start always has room around it.
  assign p_eff       = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
  assign tick        = ((state == ST_RUN) || (state == ST_WAIT)) && (per_cnt == '0);
  // to_cnt is 0 in the first WAIT cycle, so TIMEOUT-1 marks the last allowed one.
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));

  // All outputs are registered; the flag outputs are derived from the
  // next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      per_cnt     <= '0;
      to_cnt      <= '0;
      mask        <= '0;
      kp          <= '0;
      ki          <= '0;
      kd          <= '0;
      core_start  <= 1'b0;
      gains_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      fault       <= 1'b0;
      cfg_ready   <= 1'b0;
    end else begin
      state       <= state_next;
      per_cnt     <= per_cnt_next;
      to_cnt      <= to_cnt_next;
      mask        <= mask_next;
      kp          <= kp_next;
      ki          <= ki_next;
      kd          <= kd_next;
      core_start  <= start_next;
      gains_valid <= &mask_next;
      busy        <= (state_next == ST_RUN) || (state_next == ST_WAIT);
      overrun     <= overrun_next;
      fault       <= (state_next == ST_FAULT);
      cfg_ready   <= (state_next == ST_IDLE);
    end
  end

  // Next-state and datapath decisions. In WAIT the priority is
  // core_done > timeout > tick.
  always_comb begin
    state_next   = state;
    per_cnt_next = per_cnt;
    to_cnt_next  = to_cnt;
    mask_next    = mask;
    kp_next      = kp;
    ki_next      = ki;
    kd_next      = kd;
    start_next   = 1'b0;
    overrun_next = overrun;

    case (state)
      ST_IDLE: begin
        if (clear_fault) begin
          overrun_next = 1'b0;
        end
        if (cfg_fire) begin
          case (gain_sel_t'(cfg_data[5:4]))
            SEL_KP: begin
              kp_next      = lut_gain;
              mask_next[0] = 1'b1;
            end
            SEL_KI: begin
              ki_next      = lut_gain;
              mask_next[1] = 1'b1;
            end
            SEL_KD: begin
              kd_next      = lut_gain;
              mask_next[2] = 1'b1;
            end
            default: ;
          endcase
        end else if (enable && gains_valid) begin
          state_next   = ST_RUN;
          per_cnt_next = p_eff;
        end
      end

      ST_RUN: begin
        per_cnt_next = tick ? p_eff : per_cnt - PERIOD_W'(1);
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          start_next  = 1'b1;
          to_cnt_next = '0;
          state_next  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        per_cnt_next = tick ? p_eff : per_cnt - PERIOD_W'(1);
        to_cnt_next  = to_cnt + TO_W'(1);
        if (core_done) begin
          if (!enable) begin
            state_next = ST_IDLE;
          end else if (tick) begin
            // The finished sample and the new tick share this edge, so the
            // pass through RUN collapses and the next start goes out now.
            start_next  = 1'b1;
            to_cnt_next = '0;
          end else begin
            state_next = ST_RUN;
          end
        end else if (timeout_hit) begin
          state_next = ST_FAULT;
        end else if (tick) begin
          overrun_next = 1'b1;
        end
      end

      ST_FAULT: begin
        if (clear_fault) begin
          state_next   = ST_IDLE;
          overrun_next = 1'b0;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// tb_pid_loop_sequencer
// Directed bench for pid_loop_sequencer: gain loading and decode, periodic
// starts, overrun, core timeout, clamped period with coincident done, and
// asynchronous reset in the middle of a core run.
module tb_pid_loop_sequencer;

  localparam int PERIOD_W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enable = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [7:0]          cfg_data = 8'h00;
  logic [PERIOD_W-1:0] period = '0;
  logic                core_start;
  logic                core_done = 1'b0;
  logic [8:0]          kp, ki, kd;
  logic                gains_valid, busy, overrun, fault;
  logic                clear_fault = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0] lut_data [6] = '{8'h00, 8'h05, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
  int         lut_exp  [6] = '{0, 25, 100, 150, 250, 350};

  pid_loop_sequencer #(
    .TIMEOUT  (255),
    .PERIOD_W (PERIOD_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .period      (period),
    .core_start  (core_start),
    .core_done   (core_done),
    .kp          (kp),
    .ki          (ki),
    .kd          (kd),
    .gains_valid (gains_valid),
    .busy        (busy),
    .overrun     (overrun),
    .fault       (fault),
    .clear_fault (clear_fault)
  );

  always #5 clk = ~clk;

  // Bench-side cycle count used to time starts.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_data  = d;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // core_done is high during the k-th cycle after the current one.
  task automatic pulse_done_at(input int k);
    repeat (k) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  // Returns the cycle of the next core_start, or a far-off value on timeout.
  task automatic wait_start(input int bound, output int at_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (core_start !== 1'b1 && n < bound);
    at_cyc = (core_start === 1'b1) ? cyc : -100000;
  endtask

  initial begin
    int s, prev, c0;

    // Reset state
    period = 16'd9;
    step(1);
    check_output("rst_cfg_ready", cfg_ready, 0);
    check_output("rst_flags", {core_start, gains_valid, busy, overrun, fault}, 0);
    check_output("rst_gains", {kp, ki, kd}, 0);
    rst = 1'b0;
    step(1);
    check_output("post_rst_cfg_ready", cfg_ready, 1);

    // Gain loading
    cfg_write(8'h0A);
    check_output("kp_50", kp, 50);
    check_output("gv_after_1", gains_valid, 0);
    cfg_write(8'h1F);
    check_output("ki_500", ki, 500);
    check_output("gv_after_2", gains_valid, 0);
    cfg_write(8'h23);
    check_output("kd_15", kd, 15);
    check_output("gv_after_3", gains_valid, 1);
    cfg_write(8'h3F);
    check_output("sel11_nochange", {kp, ki, kd}, {9'd50, 9'd500, 9'd15});
    check_output("sel11_gv", gains_valid, 1);
    for (int i = 0; i < 6; i++) begin
      cfg_write(lut_data[i]);
      check_output($sformatf("lut_code%0d", lut_data[i][3:0]), kp, lut_exp[i]);
    end
    cfg_write(8'h0A);
    check_output("kp_restore", kp, 50);

    // period=9, done 3 cycles after each start
    period = 16'd9;
    enable = 1'b1;
    c0 = cyc;
    wait_start(30, s);
    check_output("p9_first_latency", s - c0, 11);
    check_output("p9_cfg_ready_busy", {cfg_ready, busy}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      prev = s;
      pulse_done_at(3);
      wait_start(30, s);
      check_output("p9_spacing", s - prev, 10);
    end
    check_output("p9_overrun", overrun, 0);
    enable = 1'b0;
    pulse_done_at(1);
    check_output("stop_idle", {busy, core_start, cfg_ready}, 3'b001);

    // period=4, done 8 cycles after start -> one tick skipped
    period = 16'd4;
    enable = 1'b1;
    c0 = cyc;
    wait_start(20, s);
    check_output("p4_first_latency", s - c0, 6);
    prev = s;
    pulse_done_at(8);
    wait_start(20, s);
    check_output("p4_spacing", s - prev, 10);
    check_output("p4_overrun", overrun, 1);
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    check_output("clear_in_wait_ignored", overrun, 1);
    enable = 1'b0;
    pulse_done_at(0);
    check_output("p4_stop_idle", busy, 0);
    check_output("overrun_sticky_idle", overrun, 1);
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    check_output("clear_in_idle", overrun, 0);

    // No core_done -> timeout fault
    period = 16'd300;
    enable = 1'b1;
    wait_start(400, s);
    check_output("to_started", core_start, 1);
    step(254);
    check_output("to_last_wait_fault", fault, 0);
    check_output("to_last_wait_busy", busy, 1);
    step(1);
    check_output("to_fault", fault, 1);
    check_output("to_fault_quiet", {busy, core_start, cfg_ready}, 0);
    enable = 1'b0;
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    check_output("fault_cleared", {fault, cfg_ready}, 2'b01);
    check_output("fault_gains_kept", {kp, ki, kd}, {9'd50, 9'd500, 9'd15});
    check_output("fault_gv_kept", gains_valid, 1);

    // period=0 clamps to 2 -> starts every 3 cycles
    period = 16'd0;
    enable = 1'b1;
    c0 = cyc;
    wait_start(10, s);
    check_output("p0_first_latency", s - c0, 4);
    prev = s;
    pulse_done_at(1);
    wait_start(10, s);
    check_output("p0_spacing", s - prev, 3);
    prev = s;
    pulse_done_at(2);
    check_output("coincide_start", core_start, 1);
    check_output("coincide_spacing", cyc - prev, 3);
    check_output("coincide_overrun", overrun, 0);
    check_output("pre_rst_busy", busy, 1);

    // Asynchronous reset while the core is running
    #1 rst = 1'b1;
    #1;
    check_output("arst_start_busy", {core_start, busy}, 0);
    check_output("arst_flags", {gains_valid, overrun, fault, cfg_ready}, 0);
    check_output("arst_gains", {kp, ki, kd}, 0);
    @(negedge clk);
    rst = 1'b0;
    core_done = 1'b1;
    step(1);
    core_done = 1'b0;
    check_output("post_arst_idle", {busy, core_start, cfg_ready}, 3'b001);
    check_output("post_arst_gv", gains_valid, 0);
    step(3);
    check_output("post_arst_quiet", {busy, core_start}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
